// File: rtl/regfile_pkg.sv
// Shared definitions for the multi-port register file.
//   regfile_aw()  address width for a given register count
//   REGFILE_AW    address width of the default 32-entry configuration
//   reg_addr_t    register index of the default configuration
//   reg_data_t    register value of the default configuration
package regfile_pkg;

  localparam int REGFILE_DATA_WIDTH = 32;
  localparam int REGFILE_NUM_REGS   = 32;

  // Clamped to 1 so a degenerate count never yields a zero-width address.
  function automatic int regfile_aw(input int num_regs);
    return (num_regs < 2) ? 1 : $clog2(num_regs);
  endfunction

  localparam int REGFILE_AW = regfile_aw(REGFILE_NUM_REGS);

  typedef logic [REGFILE_AW-1:0]         reg_addr_t;
  typedef logic [REGFILE_DATA_WIDTH-1:0] reg_data_t;

endpackage

// File: rtl/regfile_scoreboard.sv
// Per-register busy bits for RAW hazard detection.
//   clk, rst_n   clock, asynchronous active-low reset
//   wr_valid     qualified write strobes (reg-0 writes already removed when hardwired)
//   wr_addr      packed write addresses, port w at [w*AW +: AW]
//   rsv_en       reserve rsv_addr (new producer issued)
//   rsv_addr     register to reserve
//   busy         one bit per register, 1 = producer in flight
module regfile_scoreboard
  import regfile_pkg::*;
#(
  parameter int NUM_REGS     = 32,
  parameter int NUM_WR_PORTS = 1,
  parameter int ZERO_REG     = 1,
  localparam int AW          = regfile_aw(NUM_REGS)
) (
  input  logic                       clk,
  input  logic                       rst_n,
  input  logic [NUM_WR_PORTS-1:0]    wr_valid,
  input  logic [NUM_WR_PORTS*AW-1:0] wr_addr,
  input  logic                       rsv_en,
  input  logic [AW-1:0]              rsv_addr,
  output logic [NUM_REGS-1:0]        busy
);

  logic [NUM_REGS-1:0] busy_nxt;

  // Writes clear first, then a reservation sets: a same-cycle reserve on the
  // written register is a newer producer and must leave the bit set.
  always_comb begin
    busy_nxt = busy;
    for (int w = 0; w < NUM_WR_PORTS; w++) begin
      if (wr_valid[w]) busy_nxt[wr_addr[w*AW +: AW]] = 1'b0;
    end
    if (rsv_en) busy_nxt[rsv_addr] = 1'b1;
    if (ZERO_REG != 0) busy_nxt[0] = 1'b0;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) busy <= '0;
    else        busy <= busy_nxt;
  end

endmodule

// File: rtl/regfile_mp.sv
// Parametrised multi-port register file with write-to-read bypass and busy
// scoreboard.
//   clk, rst_n   clock, asynchronous active-low reset
//   rs_addr      packed read addresses, port p at [p*AW +: AW]
//   rs_data      packed combinational read data, port p at [p*DATA_WIDTH +: DATA_WIDTH]
//   rs_busy      addressed register has a pending producer
//   wr_en        write strobes
//   wr_addr      packed write addresses
//   wr_data      packed write data
//   rsv_en       mark rsv_addr busy
//   rsv_addr     register to reserve
//   wr_conflict  one-cycle pulse: two or more ports wrote one address last cycle
module regfile_mp
  import regfile_pkg::*;
#(
  parameter int DATA_WIDTH   = 32,
  parameter int NUM_REGS     = 32,
  parameter int NUM_RD_PORTS = 2,
  parameter int NUM_WR_PORTS = 1,
  parameter int BYPASS       = 1,
  parameter int ZERO_REG     = 1,
  localparam int AW          = regfile_aw(NUM_REGS)
) (
  input  logic                               clk,
  input  logic                               rst_n,
  input  logic [NUM_RD_PORTS*AW-1:0]         rs_addr,
  output logic [NUM_RD_PORTS*DATA_WIDTH-1:0] rs_data,
  output logic [NUM_RD_PORTS-1:0]            rs_busy,
  input  logic [NUM_WR_PORTS-1:0]            wr_en,
  input  logic [NUM_WR_PORTS*AW-1:0]         wr_addr,
  input  logic [NUM_WR_PORTS*DATA_WIDTH-1:0] wr_data,
  input  logic                               rsv_en,
  input  logic [AW-1:0]                      rsv_addr,
  output logic                               wr_conflict
);

  logic [DATA_WIDTH-1:0]   regs [NUM_REGS];
  logic [NUM_WR_PORTS-1:0] wr_valid;
  logic [NUM_REGS-1:0]     busy;
  logic                    conflict_c;

  // A hardwired-zero target makes the write invisible everywhere: no store,
  // no forward, no scoreboard clear, no conflict. Gating with rst_n keeps
  // reads at zero while reset is held even if strobes are active.
  always_comb begin
    wr_valid = '0;
    for (int w = 0; w < NUM_WR_PORTS; w++) begin
      wr_valid[w] = rst_n && wr_en[w] &&
                    !((ZERO_REG != 0) && (wr_addr[w*AW +: AW] == '0));
    end
  end

  always_comb begin
    conflict_c = 1'b0;
    for (int i = 0; i < NUM_WR_PORTS; i++) begin
      for (int j = i + 1; j < NUM_WR_PORTS; j++) begin
        if (wr_valid[i] && wr_valid[j] &&
            (wr_addr[i*AW +: AW] == wr_addr[j*AW +: AW])) conflict_c = 1'b1;
      end
    end
  end

  // Ascending port order makes the highest-index port win a collision.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int r = 0; r < NUM_REGS; r++) regs[r] <= '0;
      wr_conflict <= 1'b0;
    end else begin
      for (int w = 0; w < NUM_WR_PORTS; w++) begin
        if (wr_valid[w]) regs[wr_addr[w*AW +: AW]] <= wr_data[w*DATA_WIDTH +: DATA_WIDTH];
      end
      wr_conflict <= conflict_c;
    end
  end

  regfile_scoreboard #(
    .NUM_REGS     (NUM_REGS),
    .NUM_WR_PORTS (NUM_WR_PORTS),
    .ZERO_REG     (ZERO_REG)
  ) u_scoreboard (
    .clk      (clk),
    .rst_n    (rst_n),
    .wr_valid (wr_valid),
    .wr_addr  (wr_addr),
    .rsv_en   (rsv_en),
    .rsv_addr (rsv_addr),
    .busy     (busy)
  );

  for (genvar p = 0; p < NUM_RD_PORTS; p++) begin : g_rd
    logic [AW-1:0]         addr;
    logic [DATA_WIDTH-1:0] data;
    logic                  fwd;

    assign addr = rs_addr[p*AW +: AW];

    always_comb begin
      data = regs[addr];
      fwd  = 1'b0;
      if (BYPASS != 0) begin
        for (int w = 0; w < NUM_WR_PORTS; w++) begin
          if (wr_valid[w] && (wr_addr[w*AW +: AW] == addr)) begin
            data = wr_data[w*DATA_WIDTH +: DATA_WIDTH];
            fwd  = 1'b1;
          end
        end
      end
      if ((ZERO_REG != 0) && (addr == '0)) data = '0;
    end

    assign rs_data[p*DATA_WIDTH +: DATA_WIDTH] = data;
    // A forwarded value is the producer's result, so the hazard is resolved.
    assign rs_busy[p] = busy[addr] & ~fwd;
  end

endmodule
